uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
Command/response controller between the UART receiver, the per-channel max-value cache and the UART transmitter. It decodes one received opcode byte and steers the cache channel select. It captures the 10-bit max value(s) and serialises them as a framed byte sequence, using the TX ready/write handshake. It replaces the ad-hoc single-byte reply FSM in the top level and adds multi-channel framing, checksum, NAK and TX-stall recovery.

Parameters:
SEL_SETTLE, 2, clk cycles from a channel_sel change until max_value is valid (range 1..15)
TX_TIMEOUT, 1024, max cycles to wait for tx_ready to drop after a write strobe (range 2..65535)
HDR_BYTE, 8'hA5, frame header byte
NAK_BYTE, 8'h15, reply byte for an unknown opcode

Ports:
clk  in  1  system clock
reset_b  in  1  synchronous, active-low reset
rx_data  in  8  received opcode byte, valid while rx_ready is high
rx_ready  in  1  one-cycle pulse: new byte on rx_data
max_value  in  10  cache output for the channel selected by channel_sel
tx_ready  in  1  high = transmitter idle and able to accept a byte
channel_sel  out  3  cache channel select; channels 1..4 encoded 0..3
tx_data  out  8  byte to transmit
tx_write_en  out  1  one-cycle write strobe
tx_en  out  1  one-cycle transmit enable, coincident with tx_write_en
busy  out  1  high from the opcode capture until the frame completes or aborts
cmd_dropped  out  1  one-cycle pulse: rx_ready arrived while busy
tx_timeout  out  1  one-cycle pulse: frame aborted on timeout

Behaviour:
- Reset values: channel_sel=0, tx_data=0, tx_write_en=0, tx_en=0, busy=0, cmd_dropped=0, tx_timeout=0. Reset also clears FSM=IDLE, counters, capture registers and checksum.
- Reset mid-frame abandons the frame. Nothing further is emitted after the reset edge.
- All outputs are registered.
- FSM states: IDLE, DECODE, SETTLE, CAPTURE, LOAD, STROBE, WAIT_ACCEPT, WAIT_DONE.
- IDLE:
  - rx_ready=1 latches rx_data into the opcode register and moves to DECODE.
  - busy goes high on the next cycle.
- DECODE (1 cycle):
  - Opcode 0x01..0x04: channel list = {op-1}.
  - Opcode 0x0F: channel list = 0,1,2,3 in order.
  - Any other opcode: frame = NAK_BYTE only; skip straight to LOAD.
  - For channel commands, channel_sel is set to the first listed channel and the FSM goes to SETTLE.
- SETTLE / CAPTURE:
  - Wait SEL_SETTLE cycles, then register max_value into the hold register for that channel.
  - If more channels remain, advance channel_sel and repeat SETTLE.
  - All max_value capture completes before any byte is sent. The frame is a consistent snapshot even if the cache updates during transmission.
- Frame contents:
  - Single channel (4 bytes): HDR, {6'b0,v[9:8]}, v[7:0], CHK.
  - All channels (10 bytes): HDR, then hi/lo for ch1..ch4, then CHK.
  - CHK = XOR of all bytes between HDR and CHK. HDR is not included.
- LOAD: place the next byte on tx_data.
- STROBE:
  - Entered when tx_ready=1.
  - Assert tx_write_en and tx_en for exactly 1 cycle. tx_data is stable from LOAD through WAIT_DONE.
- WAIT_ACCEPT:
  - Wait for tx_ready=0; the cycle counter starts at the strobe.
  - If TX_TIMEOUT cycles elapse with tx_ready still high: pulse tx_timeout, go to IDLE, drop busy.
- WAIT_DONE:
  - Wait for tx_ready=1 (no timeout).
  - Then go to LOAD for the next byte, or to IDLE after the last byte. busy drops on the IDLE entry cycle.
- Latency: rx_ready at cycle 0, transmitter idle.
  - Channel command: first strobe at cycle 3+SEL_SETTLE×N, where N = number of channels.
  - NAK: first strobe at cycle 3.
- cmd_dropped:
  - Pulses for any rx_ready seen while busy=1, including on the cycle busy falls.
  - The dropped byte is not queued and does not affect the current frame.
- rx_ready in the IDLE cycle that follows frame completion is accepted normally.
- channel_sel holds its last value in IDLE.

Test Plan:
1. Reset, opcode 0x02, ch2 max=0x2B7, SEL_SETTLE=2. Response: channel_sel=1, bytes A5,02,B7,B5, first strobe at cycle 5, busy low after the 4th byte completes.
2. Opcode 0x0F, channel values 0x3FF,0x000,0x155,0x2AA. Response: bytes A5,03,FF,00,00,01,55,02,AA,00. channel_sel steps 0,1,2,3 before the first strobe. Changing max_value during transmission does not alter the bytes.
3. Opcode 0x7E. Response: a single byte 0x15, first strobe at cycle 3, no channel_sel change, busy low after completion.
4. Opcode 0x01 followed by 0x03 mid-frame. Response: cmd_dropped pulses once, only the ch1 frame is sent, next opcode 0x03 after idle is served normally.
5. Transmitter holds tx_ready=1 permanently, TX_TIMEOUT=16. Response: a single strobe, tx_timeout pulses 16 cycles later, busy=0, FSM accepts the next opcode.
6. reset_b low for 1 cycle during byte 5 of a 0x0F frame. Response: all outputs at reset values next cycle, no further strobes, next opcode 0x04 yields a correct 4-byte frame.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
// Opcode decoder and framed reply generator between UART RX, max-value cache and UART TX.
// Captures every requested channel first, then streams HDR, hi/lo pairs and an XOR checksum.
module uart_cmd_sequencer #(
   parameter int unsigned SEL_SETTLE = 2,
   parameter int unsigned TX_TIMEOUT = 1024,
   parameter logic [7:0]  HDR_BYTE   = 8'hA5,
   parameter logic [7:0]  NAK_BYTE   = 8'h15
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   input  logic [9:0] max_value,
   input  logic       tx_ready,
   output logic [2:0] channel_sel,
   output logic [7:0] tx_data,
   output logic       tx_write_en,
   output logic       tx_en,
   output logic       busy,
   output logic       cmd_dropped,
   output logic       tx_timeout
);

   typedef enum logic [2:0] {
      IDLE, DECODE, SETTLE, CAPTURE, LOAD, STROBE, WAIT_ACCEPT, WAIT_DONE
   } state_t;

   localparam bit          NO_SETTLE   = (SEL_SETTLE <= 1);
   localparam logic [3:0]  SETTLE_LAST = (SEL_SETTLE > 1) ? 4'(SEL_SETTLE - 2) : 4'd0;
   localparam logic [15:0] TO_LAST     = 16'(TX_TIMEOUT - 1);

   state_t      state;
   logic [7:0]  opcode;
   logic        all_ch;
   logic [3:0]  idx;
   logic [3:0]  last_idx;
   logic [3:0]  settle_cnt;
   logic [15:0] wait_cnt;
   logic [7:0]  chk;
   logic [9:0]  hold [4];

   logic [3:0]  nidx;
   logic [1:0]  nch;
   logic [9:0]  nval;
   logic [7:0]  nbyte;
   logic [1:0]  ch_first;
   logic        is_single;

   assign ch_first  = opcode[1:0] - 2'd1;
   assign is_single = (opcode >= 8'd1) && (opcode <= 8'd4);
   assign nidx      = idx + 4'd1;

   // Byte following the one on tx_data: odd positions carry hi bits, even carry lo.
   always_comb begin
      nch   = all_ch ? idx[2:1] : channel_sel[1:0];
      nval  = hold[nch];
      nbyte = nval[7:0];
      if (nidx == last_idx)
         nbyte = chk;
      else if (nidx[0])
         nbyte = {6'b0, nval[9:8]};
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state       <= IDLE;
         opcode      <= '0;
         all_ch      <= 1'b0;
         idx         <= '0;
         last_idx    <= '0;
         settle_cnt  <= '0;
         wait_cnt    <= '0;
         chk         <= '0;
         hold        <= '{default: '0};
         channel_sel <= '0;
         tx_data     <= '0;
         tx_write_en <= 1'b0;
         tx_en       <= 1'b0;
         busy        <= 1'b0;
         cmd_dropped <= 1'b0;
         tx_timeout  <= 1'b0;
      end else begin
         tx_write_en <= 1'b0;
         tx_en       <= 1'b0;
         tx_timeout  <= 1'b0;
         cmd_dropped <= rx_ready & busy;
         unique case (state)
            IDLE: begin
               if (rx_ready) begin
                  opcode <= rx_data;
                  busy   <= 1'b1;
                  state  <= DECODE;
               end
            end
            DECODE: begin
               chk        <= '0;
               idx        <= '0;
               settle_cnt <= '0;
               if (is_single) begin
                  all_ch      <= 1'b0;
                  last_idx    <= 4'd3;
                  channel_sel <= {1'b0, ch_first};
                  state       <= NO_SETTLE ? CAPTURE : SETTLE;
               end else if (opcode == 8'h0F) begin
                  all_ch      <= 1'b1;
                  last_idx    <= 4'd9;
                  channel_sel <= '0;
                  state       <= NO_SETTLE ? CAPTURE : SETTLE;
               end else begin
                  all_ch   <= 1'b0;
                  last_idx <= '0;
                  tx_data  <= NAK_BYTE;
                  state    <= LOAD;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST)
                  state <= CAPTURE;
               else
                  settle_cnt <= settle_cnt + 4'd1;
            end
            CAPTURE: begin
               hold[channel_sel[1:0]] <= max_value;
               chk <= chk ^ {6'b0, max_value[9:8]} ^ max_value[7:0];
               if (all_ch && channel_sel != 3'd3) begin
                  channel_sel <= channel_sel + 3'd1;
                  settle_cnt  <= '0;
                  state       <= NO_SETTLE ? CAPTURE : SETTLE;
               end else begin
                  tx_data <= HDR_BYTE;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               if (tx_ready) begin
                  tx_write_en <= 1'b1;
                  tx_en       <= 1'b1;
                  state       <= STROBE;
               end
            end
            STROBE: begin
               wait_cnt <= 16'd1;
               state    <= WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
               if (!tx_ready) begin
                  state <= WAIT_DONE;
               end else if (wait_cnt == TO_LAST) begin
                  tx_timeout <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            WAIT_DONE: begin
               if (tx_ready) begin
                  if (idx == last_idx) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     idx     <= nidx;
                     tx_data <= nbyte;
                     state   <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: table of opcode/value vectors with
// hand-computed frames, plus timeout and mid-frame reset sequences.
module tb_uart_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset_b;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic [9:0] max_value;
   logic       tx_ready = 1'b1;
   logic [2:0] channel_sel;
   logic [7:0] tx_data;
   logic       tx_write_en;
   logic       tx_en;
   logic       busy;
   logic       cmd_dropped;
   logic       tx_timeout;

   logic [9:0] mem [4];
   bit         stuck = 1'b0;
   int         cyc = 0;
   int         t0 = 0;
   int         checks = 0;
   int         errors = 0;
   int         ndrop = 0;
   int         nto = 0;
   int         to_cyc = 0;
   int         bcnt = 0;
   logic [7:0] got [$];
   int         scyc [$];

   assign max_value = mem[channel_sel[1:0]];

   uart_cmd_sequencer #(
      .SEL_SETTLE(2),
      .TX_TIMEOUT(16),
      .HDR_BYTE(8'hA5),
      .NAK_BYTE(8'h15)
   ) dut (
      .clk(clk),
      .reset_b(reset_b),
      .rx_data(rx_data),
      .rx_ready(rx_ready),
      .max_value(max_value),
      .tx_ready(tx_ready),
      .channel_sel(channel_sel),
      .tx_data(tx_data),
      .tx_write_en(tx_write_en),
      .tx_en(tx_en),
      .busy(busy),
      .cmd_dropped(cmd_dropped),
      .tx_timeout(tx_timeout)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Transmitter model: busy for 3 cycles after each write unless stuck.
   initial forever begin
      @(negedge clk);
      if (!stuck && tx_write_en) begin
         tx_ready = 1'b0;
         bcnt = 3;
      end else if (bcnt > 0) begin
         bcnt--;
         if (bcnt == 0) tx_ready = 1'b1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (tx_write_en) begin
         got.push_back(tx_data);
         scyc.push_back(cyc);
      end
      if (cmd_dropped) ndrop++;
      if (tx_timeout) begin
         nto++;
         to_cyc = cyc;
      end
   end

   typedef struct packed {
      logic [7:0]      op;
      logic [3:0][9:0] v;
      logic [3:0]      n;
      logic [79:0]     b;
      logic [4:0]      strobe;
      logic [2:0]      sel;
      logic [2:0]      nsel;
      logic            drop;
   } vec_t;

   vec_t tv [8];

   function automatic vec_t mk(input logic [7:0] op,
                               input logic [9:0] v0, input logic [9:0] v1,
                               input logic [9:0] v2, input logic [9:0] v3,
                               input logic [3:0] n, input logic [79:0] b,
                               input logic [4:0] st, input logic [2:0] sel,
                               input logic [2:0] nsel, input logic drop);
      vec_t r;
      r.op = op;
      r.v[0] = v0;
      r.v[1] = v1;
      r.v[2] = v2;
      r.v[3] = v3;
      r.n = n;
      r.b = b;
      r.strobe = st;
      r.sel = sel;
      r.nsel = nsel;
      r.drop = drop;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int b0, d0, k, first, inj;
      bit seen, chg;
      logic [2:0] selq [$];
      logic [8:0] act;
      for (int i = 0; i < 4; i++) mem[i] = v.v[i];
      b0 = got.size();
      d0 = ndrop;
      seen = 1'b0;
      chg = 1'b0;
      inj = 0;
      first = -1;
      k = 0;
      rx_data = v.op;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      t0 = cyc;
      chk($sformatf("busy_rise op%0h", v.op), busy, 1);
      while (busy && k < 600) begin
         if (inj == 1) begin
            rx_ready = 1'b0;
            inj = 2;
         end
         if (!seen && cyc > t0 && (selq.size() == 0 || selq[$] != channel_sel))
            selq.push_back(channel_sel);
         if (tx_write_en || tx_en)
            chk("en_pair", tx_en, tx_write_en);
         if (tx_write_en && !seen) begin
            seen = 1'b1;
            first = cyc - t0 + 1;
            if (v.drop) begin
               rx_data = 8'h03;
               rx_ready = 1'b1;
               inj = 1;
            end
         end
         if (seen && !chg) begin
            for (int i = 0; i < 4; i++) mem[i] = ~v.v[i];
            chg = 1'b1;
         end
         @(negedge clk);
         k++;
      end
      chk($sformatf("frame_done op%0h", v.op), busy, 0);
      chk($sformatf("nbytes op%0h", v.op), got.size() - b0, v.n);
      for (int i = 0; i < int'(v.n); i++) begin
         act = (b0 + i < got.size()) ? {1'b0, got[b0 + i]} : 9'h1FF;
         chk($sformatf("byte%0d op%0h", i, v.op), act, v.b[79 - 8 * i -: 8]);
      end
      chk($sformatf("first_strobe op%0h", v.op), first, v.strobe);
      chk($sformatf("sel_final op%0h", v.op), channel_sel, v.sel);
      chk($sformatf("sel_steps op%0h", v.op), selq.size(), v.nsel);
      for (int j = 0; j < selq.size() && j < int'(v.nsel); j++)
         chk($sformatf("sel_step%0d op%0h", j, v.op), selq[j],
             int'(v.sel) - int'(v.nsel) + 1 + j);
      chk($sformatf("dropped op%0h", v.op), ndrop - d0, v.drop);
   endtask

   initial begin
      int b0, n0, k;
      logic [8:0] act;
      tv[0] = mk(8'h02, 10'h000, 10'h2B7, 10'h000, 10'h000, 4'd4,
                 {8'hA5, 8'h02, 8'hB7, 8'hB5, 48'h0}, 5'd5, 3'd1, 3'd1, 1'b0);
      tv[1] = mk(8'h0F, 10'h3FF, 10'h000, 10'h155, 10'h2AA, 4'd10,
                 80'hA5_03_FF_00_00_01_55_02_AA_00, 5'd11, 3'd3, 3'd4, 1'b0);
      tv[2] = mk(8'h7E, 10'h111, 10'h222, 10'h333, 10'h044, 4'd1,
                 {8'h15, 72'h0}, 5'd3, 3'd3, 3'd1, 1'b0);
      tv[3] = mk(8'h01, 10'h1C3, 10'h3FF, 10'h3FF, 10'h3FF, 4'd4,
                 {8'hA5, 8'h01, 8'hC3, 8'hC2, 48'h0}, 5'd5, 3'd0, 3'd1, 1'b1);
      tv[4] = mk(8'h03, 10'h001, 10'h002, 10'h2F0, 10'h004, 4'd4,
                 {8'hA5, 8'h02, 8'hF0, 8'hF2, 48'h0}, 5'd5, 3'd2, 3'd1, 1'b0);
      tv[5] = mk(8'h00, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 4'd1,
                 {8'h15, 72'h0}, 5'd3, 3'd2, 3'd1, 1'b0);
      tv[6] = mk(8'h04, 10'h0AA, 10'h0BB, 10'h0CC, 10'h080, 4'd4,
                 {8'hA5, 8'h00, 8'h80, 8'h80, 48'h0}, 5'd5, 3'd3, 3'd1, 1'b0);
      tv[7] = mk(8'h10, 10'h000, 10'h000, 10'h000, 10'h000, 4'd1,
                 {8'h15, 72'h0}, 5'd3, 3'd3, 3'd1, 1'b0);

      for (int i = 0; i < 4; i++) mem[i] = '0;
      reset_b = 1'b0;
      rx_data = '0;
      rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {channel_sel, tx_data, tx_write_en, tx_en, busy,
                         cmd_dropped, tx_timeout}, 0);
      reset_b = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(tv[i]);

      stuck = 1'b1;
      for (int i = 0; i < 4; i++) mem[i] = tv[0].v[i];
      b0 = got.size();
      n0 = nto;
      rx_data = 8'h02;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk("to_strobes", got.size() - b0, 1);
      chk("to_pulses", nto - n0, 1);
      chk("to_delay", (scyc.size() > 0) ? to_cyc - scyc[$] : -1, 16);
      chk("to_busy", busy, 0);
      chk("to_width", tx_timeout, 0);
      stuck = 1'b0;
      run_vec(tv[0]);

      for (int i = 0; i < 4; i++) mem[i] = tv[1].v[i];
      b0 = got.size();
      rx_data = 8'h0F;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      k = 0;
      while (got.size() - b0 < 5 && k < 300) begin
         @(negedge clk);
         k++;
      end
      reset_b = 1'b0;
      @(negedge clk);
      reset_b = 1'b1;
      chk("rst_mid_outs", {channel_sel, tx_data, tx_write_en, tx_en, busy,
                           cmd_dropped, tx_timeout}, 0);
      repeat (40) @(negedge clk);
      chk("rst_no_more", got.size() - b0, 5);
      chk("rst_idle", busy, 0);
      for (int i = 0; i < 5; i++) begin
         act = (b0 + i < got.size()) ? {1'b0, got[b0 + i]} : 9'h1FF;
         chk($sformatf("rst_byte%0d", i), act, tv[1].b[79 - 8 * i -: 8]);
      end
      run_vec(tv[6]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
